// File: rtl/seq_divider_64bit.sv
// Restoring integer divider (UDIV/SDIV), one quotient bit per cycle; done pulses WIDTH+2 edges after accept.
// No queuing: start is only sampled while busy is low, and results hold until the next accepted start.
module seq_divider_64bit #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] q_sr;
   logic [WIDTH-1:0] dvs_mag;
   logic [CW-1:0]    count;
   logic             sign_q, sign_r;

   logic             accept, last_step, divisor_zero;
   logic [WIDTH-1:0] dividend_mag, divisor_mag;
   logic [WIDTH:0]   p_shift;
   logic [WIDTH-1:0] diff;
   logic             carry_low, no_borrow;

   assign accept       = start && (state == IDLE || state == DONE);
   assign last_step    = (count == CW'(WIDTH - 1));
   assign divisor_zero = (divisor == '0);

   always_comb begin
      dividend_mag = dividend;
      divisor_mag  = divisor;
      if (is_signed && dividend[WIDTH-1]) dividend_mag = -dividend;
      if (is_signed && divisor[WIDTH-1])  divisor_mag  = -divisor;
   end

   // P' - {0,|d|}: the top bit of ~{0,|d|} is 1, so the WIDTH+1-bit carry-out
   // reduces to P'[WIDTH] OR the carry out of the low WIDTH bits.
   always_comb begin
      p_shift                 = {p, q_sr[WIDTH-1]};
      {carry_low, diff}       = {1'b0, p_shift[WIDTH-1:0]} + {1'b0, ~dvs_mag} + {{WIDTH{1'b0}}, 1'b1};
      no_borrow               = p_shift[WIDTH] | carry_low;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept) state_nxt = divisor_zero ? DONE : RUN;
            else        state_nxt = IDLE;
         end
         RUN:     if (last_step) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == FIX);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p           <= '0;
         q_sr        <= '0;
         dvs_mag     <= '0;
         count       <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         p       <= '0;
         q_sr    <= dividend_mag;
         dvs_mag <= divisor_mag;
         count   <= '0;
         sign_q  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         sign_r  <= is_signed & dividend[WIDTH-1];
         if (divisor_zero) begin
            quotient    <= '0;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         p     <= no_borrow ? diff : p_shift[WIDTH-1:0];
         q_sr  <= {q_sr[WIDTH-2:0], no_borrow};
         count <= count + 1'b1;
      end else if (state == FIX) begin
         quotient    <= sign_q ? -q_sr : q_sr;
         remainder   <= sign_r ? -p : p;
         div_by_zero <= 1'b0;
      end
   end

endmodule
